uart_rx_oversampled: RTL and testbench
======================================

UART_RX_OVERSAMPLED -- requirements
Module: uart_rx_oversampled

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8: number of data bits per frame, LSB first.
REQ-002 SHALL have parameter OVERSAMPLE, default 16: baud16_tick pulses per bit period.
REQ-003 SHALL have port clk, input, 1: system clock (100 MHz); single clock domain; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port baud16_tick, input, 1: one-clk-wide enable pulse at OVERSAMPLE x baud rate. It is not a clock.
REQ-006 SHALL have port rx, input, 1: asynchronous serial line; idles high.
REQ-007 SHALL have port rx_ack, input, 1: consumer accepts rx_data.
REQ-008 SHALL have port rx_data, output, DATA_BITS: last received byte.
REQ-009 SHALL have port rx_valid, output, 1: rx_data holds an unacknowledged byte.
REQ-010 SHALL have port frame_err, output, 1: one-clk pulse when the stop bit is sampled low.
REQ-011 SHALL have port overrun, output, 1: one-clk pulse when a byte is dropped because rx_valid is still set.
REQ-012 SHALL have port busy, output, 1: high whenever the state is not IDLE.

Function
REQ-013 SHALL pass rx through a 2-flop synchronizer (rx_s) clocked every clk; rx_s = rx delayed 2 clk.
REQ-014 SHALL implement states IDLE, START, DATA, STOP. Tick counter cnt is 0..OVERSAMPLE-1; bit index is 0..DATA_BITS-1.
REQ-015 SHALL, in IDLE, on a clk with baud16_tick=1 and rx_s=0, enter START with cnt=0.
REQ-016 SHALL advance cnt only on clks with baud16_tick=1. The bit decision is taken on the tick where cnt==8. On the tick where cnt==OVERSAMPLE-1, cnt wraps to 0 and the FSM moves to the next bit.
REQ-017 SHALL, in START: decision 1 (false start/glitch) -> IDLE; decision 0 -> continue; at wrap -> DATA with bit index 0.
REQ-018 SHALL, in DATA, shift each decision into a shift register at rx position index; after bit DATA_BITS-1 wraps -> STOP.
REQ-019 SHALL, in STOP, act at decision time (cnt==8) and go to IDLE in that clk, giving half a bit of margin for back-to-back frames:
- decision 1 and rx_valid=0 (or rx_ack=1 that clk) -> load rx_data, set rx_valid.
- decision 1 and rx_valid=1 with no rx_ack -> keep old rx_data, pulse overrun.
- decision 0 -> discard byte, pulse frame_err, leave rx_valid/rx_data unchanged.
REQ-020 SHALL assert rx_valid/frame_err/overrun on the clk edge following the STOP decision tick, i.e. registered, latency 1 clk.
REQ-021 SHALL clear rx_valid on the clk after rx_ack=1. When rx_ack coincides with a new byte load, rx_valid stays 1 with the new data and no overrun occurs.
REQ-022 SHALL ignore rx_ack while rx_valid=0.
REQ-023 SHALL not require rx_s to return high between frames. Falling-edge detection is not required: a low line in IDLE starts a frame.
REQ-024 SHALL ignore baud16_tick-independent rx changes except via the synchronizer.

Reset
REQ-025 SHALL, while reset=1 at a clk edge, set state=IDLE, cnt=0, index=0, shift register=0, rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0, and synchronizer flops=1.
REQ-026 SHALL, when reset occurs mid-frame, abandon the frame with no pulses; reception resumes at the next start bit after reset deasserts.
REQ-027 SHALL give reset priority over baud16_tick and rx_ack in the same clk.

Configuration
REQ-028 SHALL honor macro UART_RX_MAJORITY_EN:
- defined: each decision is the 2-of-3 majority of rx_s sampled on ticks cnt==6, 7, 8.
- undefined: each decision is rx_s on tick cnt==8 only.
- Decision timing, latency and all other behaviour are identical in both builds.

Verification
REQ-029 SHALL be verified by a frame test: tick every 4 clk; frame 0x55 with a 1 stop bit -> rx_data=0x55, rx_valid=1 one clk after the stop decision tick, frame_err=0.
REQ-030 SHALL be verified by a glitch test: rx low for 5 ticks then high -> FSM returns to IDLE at cnt==8, no rx_valid, busy drops.
REQ-031 SHALL be verified by a framing-error test: frame 0xA3 with stop bit 0 -> frame_err one-clk pulse, rx_valid stays 0, rx_data unchanged.
REQ-032 SHALL be verified by an overrun test: two back-to-back frames 0x11, 0x22, no rx_ack -> rx_data=0x11, overrun pulse at second stop; repeat with rx_ack on the load clk -> rx_data=0x22, no overrun.
REQ-033 SHALL be verified by a reset test: reset asserted at bit 4 of a frame -> all outputs 0 next clk; next frame 0x0F is received correctly.
REQ-034 SHALL be verified by a majority test: with UART_RX_MAJORITY_EN defined, a 1-tick low glitch at cnt==7 of a high data bit -> bit still received as 1; without the macro, the same stimulus at cnt==8 -> bit received as 0.

Source files
------------

// File: rtl/uart_rx_oversampled.sv
// Oversampled UART receiver: 2-flop synchronizer, mid-bit decision, single-entry output holding register.
// Optional UART_RX_MAJORITY_EN: bit decision is the 2-of-3 vote of samples at cnt==6,7,8 instead of cnt==8 alone.
module uart_rx_oversampled #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud16_tick,
  input  logic                 rx,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;
  logic                   rx_meta_q, rx_meta_d;
  logic                   rx_s_q, rx_s_d;
  logic                   bit_dec;

`ifdef UART_RX_MAJORITY_EN
  logic samp6_q, samp6_d;
  logic samp7_q, samp7_d;

  always_comb begin
    samp6_d = samp6_q;
    samp7_d = samp7_q;
    if (baud16_tick && cnt_q == CNT_MID - CW'(2)) samp6_d = rx_s_q;
    if (baud16_tick && cnt_q == CNT_MID - CW'(1)) samp7_d = rx_s_q;
    bit_dec = (samp6_q & samp7_q) | (samp6_q & rx_s_q) | (samp7_q & rx_s_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      samp6_q <= 1'b1;
      samp7_q <= 1'b1;
    end else begin
      samp6_q <= samp6_d;
      samp7_q <= samp7_d;
    end
  end
`else
  always_comb begin
    bit_dec = rx_s_q;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      rx_meta_q   <= rx_meta_d;
      rx_s_q      <= rx_s_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    rx_meta_d   = rx;
    rx_s_d      = rx_meta_q;
    // an ack with nothing held simply has no effect
    rx_valid_d  = rx_valid_q & ~rx_ack;

    if (baud16_tick) begin
      case (state_q)
        IDLE: begin
          if (!rx_s_q) begin
            state_d = START;
            cnt_d   = '0;
          end
        end
        START: begin
          if (cnt_q == CNT_MID && bit_dec) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = DATA;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (cnt_q == CNT_MID) shift_d[idx_q] = bit_dec;
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
              state_d = STOP;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        STOP: begin
          // leave at mid stop bit so a back-to-back start edge is not missed
          if (cnt_q == CNT_MID) begin
            state_d = IDLE;
            cnt_d   = '0;
            if (bit_dec) begin
              if (!rx_valid_q || rx_ack) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
              end else begin
                overrun_d = 1'b1;
              end
            end else begin
              frame_err_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled: tick every 4 clk, bit edges aligned to ticks so decision clocks are known exactly.
module tb_uart_rx_oversampled;

  logic       clk = 1'b0;
  logic       reset;
  logic       baud16_tick = 1'b0;
  logic       rx;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_chk = 0;
  int n_err = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int div = 0;
  int fe0, ov0;
  logic pre_valid, pre_busy, post_valid, post_busy, post_fe, post_ov;

`ifdef UART_RX_MAJORITY_EN
  localparam int GLITCH_OFF = 34;
  localparam logic [7:0] GLITCH_EXP = 8'hFF;
`else
  localparam int GLITCH_OFF = 38;
  localparam logic [7:0] GLITCH_EXP = 8'hF7;
`endif

  uart_rx_oversampled #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .baud16_tick (baud16_tick),
    .rx          (rx),
    .rx_ack      (rx_ack),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .frame_err   (frame_err),
    .overrun     (overrun),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      div = (div + 1) % 4;
      baud16_tick = (div == 0);
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic align();
    do begin
      @(negedge clk);
      #1;
    end while (!baud16_tick);
  endtask

  task automatic send_bit(input logic b, input int goff);
    rx = b;
    if (goff >= 0) begin
      wait_cyc(goff);
      rx = 1'b0;
      wait_cyc(4);
      rx = b;
      wait_cyc(60 - goff);
    end else begin
      wait_cyc(64);
    end
  endtask

  // stop-bit decision lands 40 clk into the stop bit
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic ack, input int gbit);
    send_bit(1'b0, -1);
    for (int i = 0; i < 8; i++) send_bit(d[i], (i == gbit) ? GLITCH_OFF : -1);
    rx = stop_b;
    wait_cyc(40);
    rx_ack    = ack;
    pre_valid = rx_valid;
    pre_busy  = busy;
    @(posedge clk);
    #1;
    post_valid = rx_valid;
    post_busy  = busy;
    post_fe    = frame_err;
    post_ov    = overrun;
    @(negedge clk);
    #1;
    rx_ack = 1'b0;
    wait_cyc(23);
    rx = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    rx = 1'b1;
    rx_ack = 1'b0;
    wait_cyc(3);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_valid", rx_valid, 0);
    chk("rst_fe", frame_err, 0);
    chk("rst_ov", overrun, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    wait_cyc(10);

    // frame 0x55
    fe0 = fe_cnt;
    align();
    send_frame(8'h55, 1'b1, 1'b0, -1);
    chk("f55_pre_valid", pre_valid, 0);
    chk("f55_pre_busy", pre_busy, 1);
    chk("f55_post_valid", post_valid, 1);
    chk("f55_post_busy", post_busy, 0);
    chk("f55_data", rx_data, 8'h55);
    chk("f55_fe", fe_cnt - fe0, 0);

    // ack clears on the next clk, then ack with nothing held is ignored
    rx_ack = 1'b1;
    @(posedge clk);
    #1;
    chk("ack_clear", rx_valid, 0);
    wait_cyc(2);
    @(posedge clk);
    #1;
    chk("ack_idle_valid", rx_valid, 0);
    rx_ack = 1'b0;
    wait_cyc(4);

    // false start: low for 5 ticks
    align();
    rx = 1'b0;
    wait_cyc(20);
    rx = 1'b1;
    wait_cyc(20);
    chk("glitch_busy_pre", busy, 1);
    @(posedge clk);
    #1;
    chk("glitch_busy_post", busy, 0);
    chk("glitch_valid", rx_valid, 0);
    wait_cyc(40);

    // framing error
    fe0 = fe_cnt;
    align();
    send_frame(8'hA3, 1'b0, 1'b0, -1);
    chk("fe_pulse", post_fe, 1);
    chk("fe_width", fe_cnt - fe0, 1);
    chk("fe_valid", rx_valid, 0);
    chk("fe_data", rx_data, 8'h55);
    wait_cyc(80);

    // overrun: two back-to-back frames without ack
    ov0 = ov_cnt;
    align();
    send_frame(8'h11, 1'b1, 1'b0, -1);
    chk("ov_first_valid", post_valid, 1);
    send_frame(8'h22, 1'b1, 1'b0, -1);
    chk("ov_pulse", post_ov, 1);
    chk("ov_width", ov_cnt - ov0, 1);
    chk("ov_data", rx_data, 8'h11);
    chk("ov_valid", rx_valid, 1);

    // same pair with ack on the second load clk
    rx_ack = 1'b1;
    wait_cyc(1);
    rx_ack = 1'b0;
    wait_cyc(8);
    ov0 = ov_cnt;
    align();
    send_frame(8'h11, 1'b1, 1'b0, -1);
    send_frame(8'h22, 1'b1, 1'b1, -1);
    chk("ackload_ov", post_ov, 0);
    chk("ackload_cnt", ov_cnt - ov0, 0);
    chk("ackload_data", rx_data, 8'h22);
    chk("ackload_valid", rx_valid, 1);

    // reset in the middle of bit 4
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    align();
    send_bit(1'b0, -1);
    for (int i = 0; i < 4; i++) send_bit(i[0], -1);
    rx = 1'b1;
    wait_cyc(20);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst_data", rx_data, 8'h00);
    chk("mrst_valid", rx_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_fe", frame_err, 0);
    chk("mrst_ov", overrun, 0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    wait_cyc(100);
    chk("mrst_no_pulses", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
    align();
    send_frame(8'h0F, 1'b1, 1'b0, -1);
    chk("mrst_next_valid", post_valid, 1);
    chk("mrst_next_data", rx_data, 8'h0F);

    // one-tick glitch inside high data bit 3
    rx_ack = 1'b1;
    wait_cyc(1);
    rx_ack = 1'b0;
    wait_cyc(8);
    align();
    send_frame(8'hFF, 1'b1, 1'b0, 3);
    chk("maj_valid", post_valid, 1);
    chk("maj_data", rx_data, GLITCH_EXP);

    wait_cyc(10);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
